// File: rtl/seg_capture_if.sv
// Scanned 7-segment display bus and captured-frame outputs of seg_capture.
// Defining SEG_CAPTURE_BLANK_EN adds the frame_blank output.
interface seg_capture_if;
    logic        a, b, c, d, e, f, g;
    logic        dp;
    logic [7:0]  ds;
    logic        frame_ack;
    logic [31:0] frame_digits;
    logic [7:0]  frame_dp;
    logic [7:0]  frame_bad;
    logic        frame_valid;
    logic        overrun;
    logic        ds_err;
`ifdef SEG_CAPTURE_BLANK_EN
    logic [7:0]  frame_blank;

    modport master (
        output a, b, c, d, e, f, g, dp, ds, frame_ack,
        input  frame_digits, frame_dp, frame_bad, frame_valid, overrun, ds_err, frame_blank
    );
    modport slave (
        input  a, b, c, d, e, f, g, dp, ds, frame_ack,
        output frame_digits, frame_dp, frame_bad, frame_valid, overrun, ds_err, frame_blank
    );
`else
    modport master (
        output a, b, c, d, e, f, g, dp, ds, frame_ack,
        input  frame_digits, frame_dp, frame_bad, frame_valid, overrun, ds_err
    );
    modport slave (
        input  a, b, c, d, e, f, g, dp, ds, frame_ack,
        output frame_digits, frame_dp, frame_bad, frame_valid, overrun, ds_err
    );
`endif
endinterface

// File: rtl/seg_capture.sv
// Captures an 8-digit frame from a scanned 7-segment display bus.
// Optional macro SEG_CAPTURE_BLANK_EN: all-off pattern decodes as a valid blank digit.
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_capture_if.slave  seg_bus
);
    localparam int unsigned NDIG  = 8;
    localparam int unsigned SEGW  = 7;
    localparam int unsigned NIBW  = 4;
    localparam int unsigned CNTW  = 8;
    localparam int unsigned WORDW = NDIG + SEGW + 1;
    localparam int unsigned FRMW  = NDIG * NIBW;

    // Capture fires on the cycle the counter steps from STABLE_CYCLES-2 to STABLE_CYCLES-1.
    localparam logic [CNTW-1:0] CAP_CNT  = CNTW'(STABLE_CYCLES - 2);
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [NDIG-1:0] ALL_SEEN = {NDIG{1'b1}};

    // Returns {bad, nibble}; unmatched patterns give bad=1 and nibble 0.
    function automatic logic [NIBW:0] decode_seg(input logic [SEGW-1:0] seg);
        logic [NIBW:0] r;
        r = {1'b1, NIBW'(0)};
        case (seg)
            7'b0111111: r = {1'b0, 4'h0};
            7'b0000110: r = {1'b0, 4'h1};
            7'b1011011: r = {1'b0, 4'h2};
            7'b1001111: r = {1'b0, 4'h3};
            7'b1100110: r = {1'b0, 4'h4};
            7'b1101101: r = {1'b0, 4'h5};
            7'b1111101: r = {1'b0, 4'h6};
            7'b0000111: r = {1'b0, 4'h7};
            7'b1111111: r = {1'b0, 4'h8};
            7'b1101111: r = {1'b0, 4'h9};
            7'b1110111: r = {1'b0, 4'hA};
            7'b1111100: r = {1'b0, 4'hB};
            7'b0111001: r = {1'b0, 4'hC};
            7'b1011110: r = {1'b0, 4'hD};
            7'b1111001: r = {1'b0, 4'hE};
            7'b1110001: r = {1'b0, 4'hF};
`ifdef SEG_CAPTURE_BLANK_EN
            7'b0000000: r = {1'b0, 4'h0};
`endif
            default:    r = {1'b1, NIBW'(0)};
        endcase
        return r;
    endfunction

    logic [SEGW-1:0]  seg_raw_c;
    logic [SEGW-1:0]  seg_s1_q, seg_s2_q;
    logic             dp_s1_q, dp_s2_q;
    logic [NDIG-1:0]  ds_s1_q, ds_s2_q;

    logic [WORDW-1:0] word_c, word_q;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [NDIG-1:0]  seen_q, seen_d;
    logic [FRMW-1:0]  work_dig_q, work_dig_d;
    logic [NDIG-1:0]  work_dp_q, work_dp_d;
    logic [NDIG-1:0]  work_bad_q, work_bad_d;

    logic [FRMW-1:0]  frame_dig_q, frame_dig_d;
    logic [NDIG-1:0]  frame_dp_q, frame_dp_d;
    logic [NDIG-1:0]  frame_bad_q, frame_bad_d;
    logic             frame_valid_q, frame_valid_d;
    logic             overrun_q, overrun_d;
    logic             ds_err_q, ds_err_d;

`ifdef SEG_CAPTURE_BLANK_EN
    logic [NDIG-1:0]  work_blank_q, work_blank_d;
    logic [NDIG-1:0]  frame_blank_q, frame_blank_d;
`endif

    logic             changed_c;
    logic             stable_hit_c;
    logic [NDIG-1:0]  ds_low_c;
    logic             one_low_c;
    logic             multi_low_c;
    logic             capture_c;
    logic             complete_c;
    logic [NIBW:0]    dec_c;
    logic [NDIG-1:0]  seen_upd_c;

    assign seg_raw_c = {seg_bus.g, seg_bus.f, seg_bus.e, seg_bus.d,
                        seg_bus.c, seg_bus.b, seg_bus.a};

    // Two-flop synchronizers; ds idles high, segments idle low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            dp_s1_q  <= 1'b0;
            dp_s2_q  <= 1'b0;
            ds_s1_q  <= '1;
            ds_s2_q  <= '1;
        end else begin
            seg_s1_q <= seg_raw_c;
            seg_s2_q <= seg_s1_q;
            dp_s1_q  <= seg_bus.dp;
            dp_s2_q  <= dp_s1_q;
            ds_s1_q  <= seg_bus.ds;
            ds_s2_q  <= ds_s1_q;
        end
    end

    // Capture and frame state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q        <= {{NDIG{1'b1}}, {SEGW{1'b0}}, 1'b0};
            cnt_q         <= '0;
            seen_q        <= '0;
            work_dig_q    <= '0;
            work_dp_q     <= '0;
            work_bad_q    <= '0;
            frame_dig_q   <= '0;
            frame_dp_q    <= '0;
            frame_bad_q   <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            ds_err_q      <= 1'b0;
`ifdef SEG_CAPTURE_BLANK_EN
            work_blank_q  <= '0;
            frame_blank_q <= '0;
`endif
        end else begin
            word_q        <= word_c;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            work_dig_q    <= work_dig_d;
            work_dp_q     <= work_dp_d;
            work_bad_q    <= work_bad_d;
            frame_dig_q   <= frame_dig_d;
            frame_dp_q    <= frame_dp_d;
            frame_bad_q   <= frame_bad_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            ds_err_q      <= ds_err_d;
`ifdef SEG_CAPTURE_BLANK_EN
            work_blank_q  <= work_blank_d;
            frame_blank_q <= frame_blank_d;
`endif
        end
    end

    // Stability tracking, digit capture and frame hand-off.
    always_comb begin
        word_c        = {ds_s2_q, seg_s2_q, dp_s2_q};
        changed_c     = (word_c != word_q);
        cnt_d         = cnt_q;
        work_dig_d    = work_dig_q;
        work_dp_d     = work_dp_q;
        work_bad_d    = work_bad_q;
        frame_dig_d   = frame_dig_q;
        frame_dp_d    = frame_dp_q;
        frame_bad_d   = frame_bad_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        ds_err_d      = ds_err_q;
`ifdef SEG_CAPTURE_BLANK_EN
        work_blank_d  = work_blank_q;
        frame_blank_d = frame_blank_q;
`endif

        if (changed_c) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNTW'(1);
        end

        ds_low_c     = ~ds_s2_q;
        one_low_c    = (ds_low_c != '0) && ((ds_low_c & (ds_low_c - NDIG'(1))) == '0);
        multi_low_c  = (ds_low_c != '0) && !one_low_c;
        stable_hit_c = !changed_c && (cnt_q == CAP_CNT);
        capture_c    = stable_hit_c && one_low_c;
        dec_c        = decode_seg(seg_s2_q);

        if (stable_hit_c && multi_low_c) begin
            ds_err_d = 1'b1;
        end

        seen_upd_c = seen_q;
        if (capture_c) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                if (ds_low_c[i]) begin
                    work_dig_d[NIBW*i +: NIBW] = dec_c[NIBW-1:0];
                    work_dp_d[i]               = dp_s2_q;
                    work_bad_d[i]              = dec_c[NIBW];
`ifdef SEG_CAPTURE_BLANK_EN
                    work_blank_d[i]            = (seg_s2_q == '0);
`endif
                end
            end
            seen_upd_c = seen_q | ds_low_c;
        end

        complete_c = (seen_upd_c == ALL_SEEN);
        seen_d     = complete_c ? '0 : seen_upd_c;

        if (complete_c) begin
            if (!frame_valid_q || seg_bus.frame_ack) begin
                frame_dig_d   = work_dig_d;
                frame_dp_d    = work_dp_d;
                frame_bad_d   = work_bad_d;
`ifdef SEG_CAPTURE_BLANK_EN
                frame_blank_d = work_blank_d;
`endif
                frame_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (seg_bus.frame_ack && frame_valid_q) begin
            frame_valid_d = 1'b0;
        end
    end

    assign seg_bus.frame_digits = frame_dig_q;
    assign seg_bus.frame_dp     = frame_dp_q;
    assign seg_bus.frame_bad    = frame_bad_q;
    assign seg_bus.frame_valid  = frame_valid_q;
    assign seg_bus.overrun      = overrun_q;
    assign seg_bus.ds_err       = ds_err_q;
`ifdef SEG_CAPTURE_BLANK_EN
    assign seg_bus.frame_blank  = frame_blank_q;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: spec vectors, decode table and a dwell-level random model.
module tb_seg_capture;
    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_capture_if bus ();

    seg_capture #(.STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_bus (bus.slave)
    );

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] nib;
        logic       bad;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] pats [16];
    vec_t       tbl  [24];

    // Dwell-level reference model state.
    logic [3:0]  m_dig [8];
    logic [7:0]  m_dp, m_bad, m_blank, m_seen;
    logic [31:0] f_dig;
    logic [7:0]  f_dp, f_bad, f_blank;
    logic        f_valid, m_ovr, m_dserr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] dsv, input logic [6:0] seg, input logic dpv);
        bus.ds = dsv;
        {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = seg;
        bus.dp = dpv;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_dig[k] = 4'h0;
        m_dp = '0; m_bad = '0; m_blank = '0; m_seen = '0;
        f_dig = '0; f_dp = '0; f_bad = '0; f_blank = '0;
        f_valid = 1'b0; m_ovr = 1'b0; m_dserr = 1'b0;
    endtask

    task automatic ref_decode(input logic [6:0] seg, output logic [3:0] nib,
                              output logic bad, output logic blank);
        nib = 4'h0; bad = 1'b1; blank = 1'b0;
        for (int k = 0; k < 16; k++) if (pats[k] == seg) begin nib = 4'(k); bad = 1'b0; end
`ifdef SEG_CAPTURE_BLANK_EN
        if (seg == 7'b0) begin bad = 1'b0; blank = 1'b1; end
`endif
    endtask

    // One dwell of n cycles; a dwell of at least S cycles on a single digit is captured.
    task automatic model_dwell(input logic [7:0] dsv, input logic [6:0] seg, input logic dpv,
                               input int n, input bit ack);
        logic [3:0] nib;
        logic bad, blank;
        int idx;
        if (n < int'(S) || dsv == 8'hFF) return;
        if ($countones(~dsv) > 1) begin m_dserr = 1'b1; return; end
        idx = 0;
        for (int k = 0; k < 8; k++) if (!dsv[k]) idx = k;
        ref_decode(seg, nib, bad, blank);
        m_dig[idx] = nib; m_dp[idx] = dpv; m_bad[idx] = bad; m_blank[idx] = blank;
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin
            m_seen = '0;
            if (!f_valid || ack) begin
                for (int k = 0; k < 8; k++) f_dig[4*k +: 4] = m_dig[k];
                f_dp = m_dp; f_bad = m_bad; f_blank = m_blank; f_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (ack && f_valid) begin
            f_valid = 1'b0;
        end
    endtask

    // mode 0: plain; 1: ack during the capture cycle; 2: check completion latency.
    task automatic dwell(input logic [7:0] dsv, input logic [6:0] seg, input logic dpv,
                         input int n, input int mode);
        drive(dsv, seg, dpv);
        if (mode == 1) begin
            cycles(S + 1); bus.frame_ack = 1'b1; cycles(1); bus.frame_ack = 1'b0;
            cycles(n - int'(S) - 2);
        end else if (mode == 2) begin
            cycles(S + 1); chk("latency_early", 32'(bus.frame_valid), 32'd0);
            cycles(1);     chk("latency_hit",   32'(bus.frame_valid), 32'd1);
            cycles(n - int'(S) - 2);
        end else begin
            cycles(n);
        end
        drive(8'hFF, 7'b0, 1'b0);
        cycles(1);
        model_dwell(dsv, seg, dpv, n, mode == 1);
    endtask

    task automatic scan(input logic [31:0] vals, input logic [7:0] dps, input int last_mode);
        for (int d = 0; d < 8; d++)
            dwell(8'(~(8'h01 << d)), pats[vals[4*d +: 4]], dps[d], 10, (d == 7) ? last_mode : 0);
        cycles(2);
    endtask

    task automatic ack_pulse();
        bus.frame_ack = 1'b1; cycles(1); bus.frame_ack = 1'b0; cycles(1);
        if (f_valid) f_valid = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},   32'(bus.frame_valid), 32'(f_valid));
        chk({tag, ".digits"},  bus.frame_digits,     f_dig);
        chk({tag, ".dp"},      32'(bus.frame_dp),    32'(f_dp));
        chk({tag, ".bad"},     32'(bus.frame_bad),   32'(f_bad));
        chk({tag, ".overrun"}, 32'(bus.overrun),     32'(m_ovr));
        chk({tag, ".ds_err"},  32'(bus.ds_err),      32'(m_dserr));
`ifdef SEG_CAPTURE_BLANK_EN
        chk({tag, ".blank"},   32'(bus.frame_blank), 32'(f_blank));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst.valid",   32'(bus.frame_valid), 32'd0);
        chk("rst.digits",  bus.frame_digits,     32'd0);
        chk("rst.dp",      32'(bus.frame_dp),    32'd0);
        chk("rst.bad",     32'(bus.frame_bad),   32'd0);
        chk("rst.overrun", 32'(bus.overrun),     32'd0);
        chk("rst.ds_err",  32'(bus.ds_err),      32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        model_reset();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] exp_dig;
        logic [7:0]  exp_dp, exp_bad, dsv;
        logic [6:0]  seg;
        logic        dpv;
        int          kind, n, d, prev_d, b0, b1;

        pats[0]  = 7'b0111111; pats[1]  = 7'b0000110; pats[2]  = 7'b1011011; pats[3]  = 7'b1001111;
        pats[4]  = 7'b1100110; pats[5]  = 7'b1101101; pats[6]  = 7'b1111101; pats[7]  = 7'b0000111;
        pats[8]  = 7'b1111111; pats[9]  = 7'b1101111; pats[10] = 7'b1110111; pats[11] = 7'b1111100;
        pats[12] = 7'b0111001; pats[13] = 7'b1011110; pats[14] = 7'b1111001; pats[15] = 7'b1110001;
        for (int i = 0; i < 16; i++) tbl[i] = '{pats[i], 1'((i % 3) == 0), 4'(i), 1'b0};
        tbl[16] = '{7'b0000001, 1'b1, 4'h0, 1'b1};
        tbl[17] = '{7'b1000000, 1'b0, 4'h0, 1'b1};
        tbl[18] = '{7'b1111111, 1'b0, 4'h8, 1'b0};
        tbl[19] = '{7'b1111110, 1'b1, 4'h0, 1'b1};
        tbl[20] = '{7'b0110000, 1'b0, 4'h0, 1'b1};
        tbl[21] = '{7'b0000111, 1'b1, 4'h7, 1'b0};
        tbl[22] = '{7'b1000001, 1'b0, 4'h0, 1'b1};
        tbl[23] = '{7'b0111111, 1'b0, 4'h0, 1'b0};

        rst_n = 1'b1;
        bus.frame_ack = 1'b0;
        drive(8'hFF, 7'b0, 1'b0);
        #1;
        do_reset();
        check_model("post_reset");

        // Basic scan 0..7.
        scan(32'h76543210, 8'h00, 0);
        chk("scan.valid",  32'(bus.frame_valid), 32'd1);
        chk("scan.digits", bus.frame_digits,     32'h76543210);
        chk("scan.bad",    32'(bus.frame_bad),   32'd0);
        check_model("scan");
        ack_pulse();
        chk("scan.ack_clears", 32'(bus.frame_valid), 32'd0);

        // Decode table, three frames of eight entries.
        for (int f = 0; f < 3; f++) begin
            exp_dig = '0; exp_dp = '0; exp_bad = '0;
            for (int k = 0; k < 8; k++) begin
                dwell(8'(~(8'h01 << k)), tbl[f*8+k].seg, tbl[f*8+k].dp, 10, 0);
                exp_dig[4*k +: 4] = tbl[f*8+k].nib;
                exp_dp[k]  = tbl[f*8+k].dp;
                exp_bad[k] = tbl[f*8+k].bad;
            end
            cycles(2);
            chk("tbl.valid",  32'(bus.frame_valid), 32'd1);
            chk("tbl.digits", bus.frame_digits,     exp_dig);
            chk("tbl.dp",     32'(bus.frame_dp),    32'(exp_dp));
            chk("tbl.bad",    32'(bus.frame_bad),   32'(exp_bad));
            ack_pulse();
        end

        // Dwell one cycle short on digit 3 is ignored.
        dwell(8'b11110111, pats[3], 1'b0, S - 1, 0);
        for (int k = 0; k < 8; k++) if (k != 3) dwell(8'(~(8'h01 << k)), pats[k], 1'b0, 10, 0);
        cycles(2);
        chk("short.no_frame", 32'(bus.frame_valid), 32'd0);
        dwell(8'b11110111, pats[3], 1'b0, 10, 0);
        cycles(2);
        chk("short.then_frame", 32'(bus.frame_valid), 32'd1);
        chk("short.nib3",       32'(bus.frame_digits[15:12]), 32'd3);
        check_model("short");
        ack_pulse();

        // Undecodable pattern on digit 5.
        for (int k = 0; k < 8; k++)
            dwell(8'(~(8'h01 << k)), (k == 5) ? 7'b0000001 : pats[k], 1'b0, 10, 0);
        cycles(2);
        chk("bad5.bad",  32'(bus.frame_bad),          32'h20);
        chk("bad5.nib5", 32'(bus.frame_digits[23:20]), 32'd0);
        check_model("bad5");
        ack_pulse();

        // Overrun, then ack coinciding with completion.
        scan(32'h89ABCDEF, 8'h0F, 0);
        scan(32'h13579BDF, 8'hF0, 0);
        chk("ovr.held",    bus.frame_digits,     32'h89ABCDEF);
        chk("ovr.flag",    32'(bus.overrun),     32'd1);
        chk("ovr.valid",   32'(bus.frame_valid), 32'd1);
        scan(32'h02468ACE, 8'h3C, 1);
        chk("ackcomp.digits", bus.frame_digits,     32'h02468ACE);
        chk("ackcomp.valid",  32'(bus.frame_valid), 32'd1);
        chk("ackcomp.ovr",    32'(bus.overrun),     32'd1);
        check_model("ackcomp");
        ack_pulse();

        // Reset mid-frame discards partial capture.
        for (int k = 4; k < 8; k++) dwell(8'(~(8'h01 << k)), pats[k + 5], 1'b1, 10, 0);
        do_reset();
        scan(32'hFEDCBA98, 8'hA5, 2);
        chk("midrst.digits", bus.frame_digits,     32'hFEDCBA98);
        chk("midrst.dp",     32'(bus.frame_dp),    32'hA5);
        chk("midrst.ovr",    32'(bus.overrun),     32'd0);
        ack_pulse();
        cycles(20);
        chk("midrst.single", 32'(bus.frame_valid), 32'd0);

        // Two digits selected at once.
        chk("dserr.before", 32'(bus.ds_err), 32'd0);
        dwell(8'b11100111, pats[8], 1'b0, 10, 0);
        cycles(2);
        chk("dserr.set",   32'(bus.ds_err),      32'd1);
        chk("dserr.valid", 32'(bus.frame_valid), 32'd0);
        check_model("dserr");

        // Randomized dwells against the model.
        do_reset();
        prev_d = 7;
        for (int it = 0; it < 300; it++) begin
            kind = int'($urandom_range(99));
            n    = int'($urandom_range(S + 3, S - 2));
            if (kind < 8) begin
                dsv = 8'hFF;
            end else if (kind < 14) begin
                b0 = int'($urandom_range(7));
                b1 = (b0 + 1 + int'($urandom_range(6))) % 8;
                dsv = 8'(~((8'h01 << b0) | (8'h01 << b1)));
            end else begin
                d = (kind < 30) ? int'($urandom_range(7)) : (prev_d + 1) % 8;
                prev_d = d;
                dsv = 8'(~(8'h01 << d));
            end
            seg = (kind >= 88) ? 7'($urandom) : pats[$urandom_range(15)];
            dpv = 1'($urandom);
            dwell(dsv, seg, dpv, n, 0);
            cycles(2);
            check_model("rand");
            if ($urandom_range(99) < 15) ack_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
